imem_loader: RTL and testbench

- Writer side of the instruction memory. The single-cycle core only reads instruction memory; this block fills it.
- Receives a framed byte stream over a valid/ready handshake, packs big-endian 32-bit words and issues one-cycle writes to the instruction-memory write port.
- Holds the core in reset while loading. On a good checksum it releases the core at the frame's start PC for a fixed cycle budget, then halts it and pulses done.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_word_packer.sv | 42 ++++
 rtl/imem_loader.sv | 173 +++++++++++++++++
 tb/tb_imem_loader.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: states and framing constants shared by the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_H,
        ADDR_L,
        CNT_H,
        CNT_L,
        PAYLOAD,
        CHECK,
        RUN
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: assembles big-endian 32-bit words from a byte stream, one pulse per full word.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        last_byte
);
    localparam int CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0] byte_cnt;

    assign last_byte = (byte_cnt == CNT_W'(WORD_BYTES - 1));

    // Shift bytes in MS-first; word_valid is high only in the cycle after the final byte of a word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word       <= '0;
            word_valid <= 1'b0;
            byte_cnt   <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_cnt <= '0;
            end else if (shift_en) begin
                word <= {word[23:0], byte_in};
                if (last_byte) begin
                    byte_cnt   <= '0;
                    word_valid <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream, fills instruction memory and runs the core for a fixed budget.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int RUN_CYCLES = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic [31:0]       inicioPC,
    output logic              done,
    output logic              err
);
    localparam int RUN_W = $clog2(RUN_CYCLES + 1);

    loader_state_t     state;
    loader_state_t     state_next;
    logic [7:0]        hdr_hi;
    logic [15:0]       hdr_word;
    logic [15:0]       words_left;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] addr_cnt;
    logic [7:0]        csum;
    logic [RUN_W-1:0]  run_cnt;
    logic              accept;
    logic              is_sync;
    logic              pack_clear;
    logic              pack_shift;
    logic              pack_valid;
    logic              pack_last;
    logic [31:0]       pack_word;

    assign byte_ready = (state != RUN);
    assign accept     = byte_valid && (state != RUN);
    assign is_sync    = (byte_in == SYNC_BYTE);
    assign hdr_word   = {hdr_hi, byte_in};
    assign mem_we     = pack_valid;
    assign mem_addr   = addr_cnt;
    assign mem_wdata  = pack_word;

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pack_clear),
        .shift_en   (pack_shift),
        .byte_in    (byte_in),
        .word       (pack_word),
        .word_valid (pack_valid),
        .last_byte  (pack_last)
    );

    // Frame state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the run/done outputs derived from the run counter.
    always_comb begin
        state_next = state;
        cpu_run    = 1'b0;
        done       = 1'b0;
        pack_clear = 1'b0;
        pack_shift = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_sync) begin
                    state_next = ADDR_H;
                    pack_clear = 1'b1;
                end
            end
            ADDR_H:  if (accept) state_next = ADDR_L;
            ADDR_L:  if (accept) state_next = CNT_H;
            CNT_H:   if (accept) state_next = CNT_L;
            CNT_L: begin
                if (accept) begin
                    state_next = (hdr_word == 16'd0) ? CHECK : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    pack_shift = 1'b1;
                    if (pack_last && (words_left == 16'd1)) begin
                        state_next = CHECK;
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    state_next = (byte_in == csum) ? RUN : IDLE;
                end
            end
            RUN: begin
                if (run_cnt == '0) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else begin
                    cpu_run = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Header capture, write address, payload checksum, run budget and the sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_hi     <= '0;
            words_left <= '0;
            start_addr <= '0;
            addr_cnt   <= '0;
            csum       <= '0;
            run_cnt    <= '0;
            inicioPC   <= '0;
            err        <= 1'b0;
        end else begin
            if (pack_valid) begin
                addr_cnt <= addr_cnt + ADDR_W'(1);
            end
            case (state)
                IDLE: begin
                    if (accept && is_sync) begin
                        err  <= 1'b0;
                        csum <= '0;
                    end
                end
                ADDR_H, CNT_H: begin
                    if (accept) hdr_hi <= byte_in;
                end
                ADDR_L: begin
                    if (accept) begin
                        start_addr <= hdr_word[ADDR_W-1:0];
                        addr_cnt   <= hdr_word[ADDR_W-1:0];
                    end
                end
                CNT_L: begin
                    if (accept) words_left <= hdr_word;
                end
                PAYLOAD: begin
                    if (accept) begin
                        csum <= csum ^ byte_in;
                        if (pack_last) words_left <= words_left - 16'd1;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        if (byte_in == csum) begin
                            inicioPC <= 32'({start_addr, 2'b00});
                            run_cnt  <= RUN_W'(RUN_CYCLES);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (run_cnt != '0) run_cnt <= run_cnt - RUN_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: frame-level reference model with a per-cycle compare against imem_loader.
module tb_imem_loader;
    localparam int ADDR_W     = 8;
    localparam int RUN_CYCLES = 50;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_run;
    logic [31:0]       inicioPC;
    logic              done;
    logic              err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Reference model: scheduled write events keyed by cycle, run window, flags.
    bit                exp_we   [int];
    logic [ADDR_W-1:0] exp_addr [int];
    logic [31:0]       exp_data [int];
    int                run_lo  = -10;
    int                run_hi  = -10;
    int                done_at = -10;
    logic              m_err   = 1'b0;
    logic [31:0]       m_pc    = 32'd0;

    logic [31:0] fw[$];
    logic [39:0] obs_w[$];
    int          obs_done = 0;

    imem_loader #(.ADDR_W(ADDR_W), .RUN_CYCLES(RUN_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_run    (cpu_run),
        .inicioPC   (inicioPC),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit model_ready(input int c);
        return !(c >= run_lo && c <= done_at);
    endfunction

    function automatic logic [7:0] xsum();
        logic [7:0] s;
        s = 8'h00;
        foreach (fw[k]) s = s ^ fw[k][31:24] ^ fw[k][23:16] ^ fw[k][15:8] ^ fw[k][7:0];
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    task automatic modelReset();
        exp_we.delete();
        exp_addr.delete();
        exp_data.delete();
        run_lo  = -10;
        run_hi  = -10;
        done_at = -10;
        m_err   = 1'b0;
        m_pc    = 32'd0;
    endtask

    // Per-cycle comparison of every output against the model, sampled on the falling edge.
    always @(negedge clk) begin : compare
        int c;
        if (chk_en) begin
            c = cyc;
            if (!rst) begin
                checkOutput("rst_flags", 40'({mem_we, cpu_run, done, byte_ready, err}), 40'(5'b00010));
                checkOutput("rst_pc", 40'(inicioPC), 40'd0);
            end else begin
                checkOutput("mem_we", 40'(mem_we), 40'(exp_we.exists(c)));
                if (exp_we.exists(c)) begin
                    checkOutput("mem_addr", 40'(mem_addr), 40'(exp_addr[c]));
                    checkOutput("mem_wdata", 40'(mem_wdata), 40'(exp_data[c]));
                end
                if (mem_we) obs_w.push_back({mem_addr, mem_wdata});
                if (done) obs_done++;
                checkOutput("cpu_run", 40'(cpu_run), 40'(c >= run_lo && c <= run_hi));
                checkOutput("done", 40'(done), 40'(c == done_at));
                checkOutput("byte_ready", 40'(byte_ready), 40'(model_ready(c)));
                checkOutput("err", 40'(err), 40'(m_err));
                checkOutput("inicioPC", 40'(inicioPC), 40'(m_pc));
            end
        end
    end

    // Offer one byte after a random idle gap and hold it until the model says it was taken.
    task automatic applyStimulus(input logic [7:0] b, input int gap_max, output int acc);
        byte_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk);
            #1;
        end
        byte_in    = b;
        byte_valid = 1'b1;
        acc        = -1;
        while (acc < 0) begin
            @(posedge clk);
            #1;
            if (model_ready(cyc - 1)) acc = cyc;
        end
        byte_valid = 1'b0;
    endtask

    // Send a whole frame built from fw; a nonzero bad_xor corrupts the checksum byte.
    task automatic sendFrame(input logic [15:0] start, input logic [7:0] bad_xor, input int gap_max);
        int         n;
        logic [7:0] b;
        logic [7:0] cs;
        logic [15:0] cnt;
        cnt = 16'(fw.size());
        cs  = 8'h00;
        applyStimulus(8'hA5, gap_max, n);
        m_err = 1'b0;
        applyStimulus(start[15:8], gap_max, n);
        applyStimulus(start[7:0], gap_max, n);
        applyStimulus(cnt[15:8], gap_max, n);
        applyStimulus(cnt[7:0], gap_max, n);
        for (int k = 0; k < fw.size(); k++) begin
            for (int j = 3; j >= 0; j--) begin
                b  = fw[k][8*j +: 8];
                cs = cs ^ b;
                applyStimulus(b, gap_max, n);
            end
            exp_we[n]   = 1'b1;
            exp_addr[n] = ADDR_W'(start) + ADDR_W'(k);
            exp_data[n] = fw[k];
        end
        applyStimulus(cs ^ bad_xor, gap_max, n);
        if (bad_xor == 8'h00) begin
            m_pc    = 32'(start[ADDR_W-1:0]) * 32'd4;
            run_lo  = n;
            run_hi  = n + RUN_CYCLES - 1;
            done_at = n + RUN_CYCLES;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic waitRunEnd();
        while (cyc <= done_at + 1) begin
            @(posedge clk);
            #1;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic asyncResetCheck();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_flags", 40'({mem_we, cpu_run, done, byte_ready, err}), 40'(5'b00010));
        checkOutput("async_rst_data", 40'({mem_addr, mem_wdata}), 40'd0);
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : stimulus
        int          n;
        int          base;
        int          d0;
        int          nw;
        int          nj;
        logic [7:0]  jb;
        logic [7:0]  bx;
        logic [15:0] st;

        rst        = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        chk_en     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic load; the XOR of the eight payload bytes is 0x55.
        fw = {32'h20080005, 32'h01095020};
        checkOutput("model_csum_basic", 40'(xsum()), 40'h55);
        base = obs_w.size();
        d0   = obs_done;
        sendFrame(16'h0000, 8'h00, 2);
        waitRunEnd();
        checkOutput("basic_w0", obs_w[base], {8'h00, 32'h20080005});
        checkOutput("basic_w1", obs_w[base+1], {8'h01, 32'h01095020});
        checkOutput("basic_done_cnt", 40'(obs_done - d0), 40'd1);
        checkOutput("basic_pc", 40'(inicioPC), 40'd0);

        // Offset start at word 14.
        fw = {32'h8C0A0000};
        checkOutput("model_csum_offset", 40'(xsum()), 40'h86);
        base = obs_w.size();
        sendFrame(16'd14, 8'h00, 1);
        waitRunEnd();
        checkOutput("offset_w0", obs_w[base], {8'd14, 32'h8C0A0000});
        checkOutput("offset_pc", 40'(inicioPC), 40'd56);

        // Bad checksum (0x00 sent): word still written, error raised, no run.
        base = obs_w.size();
        d0   = obs_done;
        sendFrame(16'd14, 8'h86, 1);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("bad_w0", obs_w[base], {8'd14, 32'h8C0A0000});
        checkOutput("bad_err", 40'(err), 40'd1);
        checkOutput("bad_no_done", 40'(obs_done - d0), 40'd0);

        // Address wrap from 255 to 0; the sync byte also clears err.
        fw = {32'h11223344, 32'hCAFEF00D};
        base = obs_w.size();
        sendFrame(16'h00FF, 8'h00, 1);
        waitRunEnd();
        checkOutput("wrap_a0", 40'(obs_w[base][39:32]), 40'hFF);
        checkOutput("wrap_a1", 40'(obs_w[base+1][39:32]), 40'h00);

        // Zero-length frame after discarded junk bytes.
        applyStimulus(8'h00, 1, n);
        applyStimulus(8'hFF, 1, n);
        fw.delete();
        base = obs_w.size();
        d0   = obs_done;
        sendFrame(16'd7, 8'h00, 1);
        waitRunEnd();
        checkOutput("zero_no_write", 40'(obs_w.size() - base), 40'd0);
        checkOutput("zero_done_cnt", 40'(obs_done - d0), 40'd1);
        checkOutput("zero_pc", 40'(inicioPC), 40'd28);

        // Reset after two payload bytes, then a fresh frame.
        applyStimulus(8'hA5, 0, n);
        m_err = 1'b0;
        applyStimulus(8'h00, 0, n);
        applyStimulus(8'h03, 0, n);
        applyStimulus(8'h00, 0, n);
        applyStimulus(8'h01, 0, n);
        applyStimulus(8'hDE, 0, n);
        applyStimulus(8'hAD, 0, n);
        asyncResetCheck();
        fw = {32'h20080005, 32'h01095020};
        base = obs_w.size();
        sendFrame(16'd3, 8'h00, 2);
        checkOutput("after_rst_w0", obs_w[base], {8'd3, 32'h20080005});

        // Reset in the middle of a run drops cpu_run at once.
        while (cyc < run_lo + 10) begin
            @(posedge clk);
            #1;
        end
        asyncResetCheck();

        // Randomized frames back to back, so bytes are offered during each run.
        for (int f = 0; f < 25; f++) begin
            nj = $urandom_range(0, 2);
            for (int j = 0; j < nj; j++) begin
                jb = 8'($urandom);
                if (jb == 8'hA5) jb = 8'h5A;
                applyStimulus(jb, 2, n);
            end
            nw = $urandom_range(0, 5);
            fw.delete();
            for (int k = 0; k < nw; k++) fw.push_back($urandom);
            st = 16'($urandom);
            bx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            sendFrame(st, bx, 3);
        end
        waitRunEnd();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
